sdram_line_fetch: RTL

- Read-side client that sits directly upstream of the DDR2 controller+PHY local interface in the layer-RAM pipe stage.
- On `start`, it fetches `line_words` 32-bit words beginning at `base_addr`, issuing bursts on the local interface.
- Returned `local_rdata` beats are buffered in a FIFO and presented to the pixel pipeline as a valid/ready stream.
- Credit-based issue guarantees that read data is never dropped, because the controller's read return cannot be back-pressured.

---
 rtl/sdram_local_pkg.sv | 14 +
 rtl/line_fetch_fifo.sv | 59 +++++
 rtl/sdram_line_fetch.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sdram_local_pkg.sv
// Shared local-interface widths and the fetch FSM state type for the layer-RAM read client.
package sdram_local_pkg;
    localparam int         LOCAL_ADDR_W = 26;
    localparam int         LOCAL_DATA_W = 32;
    localparam int         LOCAL_SIZE_W = 3;
    localparam logic [3:0] LOCAL_BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } fetch_state_t;
endpackage

// File: rtl/line_fetch_fifo.sv
// First-word-fall-through FIFO buffering returned read beats ahead of the pixel stream.
module line_fetch_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic                     phy_clk,
    input  logic                     reset_phy_clk_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_count == '0);
    assign w_full = (r_count == CW'(DEPTH));
    assign w_do_pop = pop && !empty;
    // A push into a full FIFO is still safe when a pop frees the slot in the same cycle.
    assign w_do_push = push && (!w_full || w_do_pop);
    assign dout = r_mem[r_rd_ptr];
    assign count = r_count;

    always_ff @(posedge phy_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (!reset_phy_clk_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/sdram_line_fetch.sv
// Credit-based line fetcher on the DDR2 local interface feeding a valid/ready pixel stream.
// Optional stall counter enabled by defining SDRAM_LINE_FETCH_PERF_EN.
module sdram_line_fetch
    import sdram_local_pkg::*;
#(
    parameter int ADDR_W     = LOCAL_ADDR_W,
    parameter int DATA_W     = LOCAL_DATA_W,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 32,
    parameter int LEN_W      = 12
) (
    input  logic                    phy_clk,
    input  logic                    reset_phy_clk_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LEN_W-1:0]        line_words,
    output logic                    busy,
    output logic                    done,
    input  logic                    local_init_done,
    input  logic                    local_ready,
    output logic                    local_read_req,
    output logic                    local_burstbegin,
    output logic [LOCAL_SIZE_W-1:0] local_size,
    output logic [ADDR_W-1:0]       local_address,
    output logic [3:0]              local_be,
    input  logic [DATA_W-1:0]       local_rdata,
    input  logic                    local_rdata_valid,
    output logic [DATA_W-1:0]       pix_data,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [15:0]             stall_cycles
);
    localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] BURST_C = LEN_W'(BURST_LEN);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [ADDR_W-1:0]       r_addr;
    logic [LEN_W-1:0]        r_rem_req;
    logic [LEN_W-1:0]        r_rem_out;
    logic [CW-1:0]           r_outstanding;
    logic                    r_hold;

    logic [CW-1:0]           w_fifo_count;
    logic                    w_fifo_empty;
    logic [DATA_W-1:0]       w_fifo_dout;
    logic [LOCAL_SIZE_W-1:0] w_nsize;
    logic [CW-1:0]           w_credit;
    logic                    w_can_issue;
    logic                    w_req;
    logic                    w_accept;
    logic                    w_beat;
    logic                    w_pop;
    logic                    w_start_ok;

    assign w_nsize = (r_rem_req >= BURST_C) ? LOCAL_SIZE_W'(BURST_LEN)
                                            : r_rem_req[LOCAL_SIZE_W-1:0];
    // Every word already buffered or still in flight owns a FIFO slot.
    assign w_credit    = DEPTH_C - w_fifo_count - r_outstanding;
    assign w_can_issue = (r_state == ISSUE) && (r_rem_req != '0) && local_init_done
                         && (w_credit >= CW'(w_nsize));
    assign w_req       = r_hold || w_can_issue;
    assign w_accept    = w_req && local_ready;
    assign w_beat      = local_rdata_valid && (r_outstanding != '0);
    assign w_pop       = pix_valid && pix_ready;
    assign w_start_ok  = (r_state == IDLE) && start;

    assign local_read_req   = w_req;
    assign local_burstbegin = w_req && !r_hold;
    assign local_size       = w_nsize;
    assign local_address    = r_addr;
    assign local_be         = LOCAL_BE_ALL;
    assign pix_valid        = !w_fifo_empty;
    assign pix_data         = w_fifo_empty ? '0 : w_fifo_dout;

    line_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .phy_clk         (phy_clk),
        .reset_phy_clk_n (reset_phy_clk_n),
        .push            (w_beat),
        .din             (local_rdata),
        .pop             (w_pop),
        .dout            (w_fifo_dout),
        .empty           (w_fifo_empty),
        .count           (w_fifo_count)
    );

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (line_words == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (r_rem_req == '0) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave on the edge of the final pop so done follows it directly.
                if ((r_rem_out == '0) || ((r_rem_out == LEN_W'(1)) && w_pop)) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge phy_clk) begin
        if (!reset_phy_clk_n) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_rem_req     <= '0;
            r_rem_out     <= '0;
            r_outstanding <= '0;
            r_hold        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_req && !local_ready;
            r_outstanding <= r_outstanding + (w_accept ? CW'(w_nsize) : CW'(0))
                                           - (w_beat ? CW'(1) : CW'(0));
            if (w_start_ok) begin
                r_addr    <= base_addr;
                r_rem_req <= line_words;
                r_rem_out <= line_words;
            end else begin
                if (w_accept) begin
                    r_addr    <= r_addr + ADDR_W'(w_nsize);
                    r_rem_req <= r_rem_req - LEN_W'(w_nsize);
                end
                if (w_pop && (r_rem_out != '0)) begin
                    r_rem_out <= r_rem_out - LEN_W'(1);
                end
            end
        end
    end

`ifdef SDRAM_LINE_FETCH_PERF_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge phy_clk) begin
        if (!reset_phy_clk_n) begin
            r_stall_cycles <= '0;
        end else if (w_start_ok) begin
            r_stall_cycles <= '0;
        end else if (busy && !pix_valid && pix_ready && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 16'h0;
`endif
endmodule
